// File: rtl/instr_loader.sv
// Program loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the CPU in reset until the image is complete.
module instr_loader #(
   parameter int unsigned                ADDRESS_WIDTH = 32,
   parameter int unsigned                DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
   parameter int unsigned                MEM_WORDS     = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_rst,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   // Extra bit so a count of exactly MEM_WORDS is representable without wrapping
   localparam int unsigned WIDX_W = $clog2(MEM_WORDS) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
   } state_e;

   state_e                     state_q, state_d;
   logic [7:0]                 len_lo_q, len_lo_d;
   logic [WIDX_W-1:0]          len_q, len_d;
   logic [WIDX_W-1:0]          widx_q, widx_d;
   logic [1:0]                 bidx_q, bidx_d;
   logic [DATA_WIDTH-1:0]      word_q, word_d;
   logic [ADDRESS_WIDTH-1:0]   addr_d;
   logic [DATA_WIDTH-1:0]      wdata_d;
   logic [15:0]                n_c;
   logic                       xfer_c;

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      widx_d   = widx_q;
      bidx_d   = bidx_q;
      word_d   = word_q;
      addr_d   = mem_addr;
      wdata_d  = mem_wdata;
      n_c      = {byte_in, len_lo_q};
      xfer_c   = byte_valid && byte_ready;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d  = S_LEN_LO;
               len_lo_d = '0;
               len_d    = '0;
               widx_d   = '0;
               bidx_d   = '0;
               word_d   = '0;
            end
         end
         S_LEN_LO: begin
            if (xfer_c) begin
               len_lo_d = byte_in;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer_c) begin
               if (n_c == 16'd0) begin
                  state_d = S_DONE;
               end else if (32'(n_c) > 32'(MEM_WORDS)) begin
                  state_d = S_ERROR;
               end else begin
                  len_d   = WIDX_W'(n_c);
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer_c) begin
               word_d[{bidx_q, 3'b000} +: 8] = byte_in;
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  addr_d  = BASE_ADDR + (ADDRESS_WIDTH'(widx_q) << 2);
                  wdata_d = word_d;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            widx_d  = widx_q + WIDX_W'(1);
            state_d = (widx_d == len_q) ? S_DONE : S_DATA;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and registered outputs (decoded from the next state)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_lo_q   <= '0;
         len_q      <= '0;
         widx_q     <= '0;
         bidx_q     <= '0;
         word_q     <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         cpu_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         len_q      <= len_d;
         widx_q     <= widx_d;
         bidx_q     <= bidx_d;
         word_q     <= word_d;
         byte_ready <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
         mem_we     <= (state_d == S_WRITE);
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         cpu_rst    <= (state_d != S_DONE);
         busy       <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                       (state_d == S_DATA)   || (state_d == S_WRITE);
         done       <= (state_d == S_DONE);
         err        <= (state_d == S_ERROR);
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader: header parsing, word assembly, write timing,
// error and empty programs, stalls, ignored start, async reset and a full-capacity load.
module tb_instr_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];

   instr_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Each mem_we pulse lasts one cycle, so one negedge sample per write
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles; returns 1 ns after the accepting edge
   task automatic send(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      byte_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      byte_in    = b;
      byte_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (byte_ready) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      byte_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed ready=0 expected ready=1 for byte %h", b);
      end
   endtask

   task automatic clear_writes();
      wq_addr.delete();
      wq_data.delete();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      #23;
      rst = 1'b0;
      tick();

      // 1. Idle after reset, then asynchronous reset mid-load
      repeat (10) tick();
      chk("idle_ready",   32'(byte_ready), 32'd0);
      chk("idle_we",      32'(mem_we),     32'd0);
      chk("idle_cpu_rst", 32'(cpu_rst),    32'd1);
      chk("idle_done",    32'(done),       32'd0);
      chk("idle_err",     32'(err),        32'd0);
      chk("idle_addr",    mem_addr,        32'h0);
      pulse_start();
      chk("lenlo_ready",  32'(byte_ready), 32'd1);
      chk("lenlo_busy",   32'(busy),       32'd1);
      #3 rst = 1'b1;
      #1;
      chk("async_ready",  32'(byte_ready), 32'd0);
      chk("async_busy",   32'(busy),       32'd0);
      chk("async_cpu_rst", 32'(cpu_rst),   32'd1);
      tick();
      rst = 1'b0;
      tick();

      // 2. Two-word program at full rate, with exact write timing on word 0
      clear_writes();
      pulse_start();
      send(8'h02, 0); send(8'h00, 0);
      send(8'h13, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
      chk("w0_we",    32'(mem_we),     32'd1);
      chk("w0_ready", 32'(byte_ready), 32'd0);
      chk("w0_addr",  mem_addr,        32'h0000_0000);
      chk("w0_data",  mem_wdata,       32'h0000_0513);
      tick();
      chk("w0_we_low",   32'(mem_we),     32'd0);
      chk("w0_ready_up", 32'(byte_ready), 32'd1);
      chk("w0_cpu_rst",  32'(cpu_rst),    32'd1);
      send(8'h93, 0); send(8'h05, 0); send(8'h15, 0); send(8'h00, 0);
      repeat (3) tick();
      chk("p2_done",    32'(done),    32'd1);
      chk("p2_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("p2_busy",    32'(busy),    32'd0);
      chk("p2_nwrites", 32'(wq_addr.size()), 32'd2);
      if (wq_addr.size() == 2) begin
         chk("p2_a0", wq_addr[0], 32'h0000_0000);
         chk("p2_d0", wq_data[0], 32'h0000_0513);
         chk("p2_a1", wq_addr[1], 32'h0000_0004);
         chk("p2_d1", wq_data[1], 32'h0015_0593);
      end

      // 3. Empty program; start from DONE reasserts cpu_rst on that edge
      clear_writes();
      pulse_start();
      chk("p3_restart_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("p3_restart_done",    32'(done),    32'd0);
      send(8'h00, 0); send(8'h00, 0);
      chk("p3_done",    32'(done),    32'd1);
      chk("p3_cpu_rst", 32'(cpu_rst), 32'd0);
      repeat (3) tick();
      chk("p3_nwrites", 32'(wq_addr.size()), 32'd0);

      // 4. Over-length header (1025) errors; a valid load afterwards recovers
      clear_writes();
      pulse_start();
      send(8'h01, 0); send(8'h04, 0);
      chk("p4_err",     32'(err),        32'd1);
      chk("p4_cpu_rst", 32'(cpu_rst),    32'd1);
      chk("p4_ready",   32'(byte_ready), 32'd0);
      chk("p4_busy",    32'(busy),       32'd0);
      repeat (4) tick();
      chk("p4_nwrites", 32'(wq_addr.size()), 32'd0);
      pulse_start();
      chk("p4_err_clr", 32'(err), 32'd0);
      send(8'h01, 0); send(8'h00, 0);
      send(8'h13, 0); send(8'h05, 0); send(8'h00, 0); send(8'h00, 0);
      repeat (3) tick();
      chk("p4_done", 32'(done), 32'd1);
      chk("p4_nwrites2", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() == 1) begin
         chk("p4_a0", wq_addr[0], 32'h0000_0000);
         chk("p4_d0", wq_data[0], 32'h0000_0513);
      end

      // 5. Stalled stream with start pulsed mid-load
      clear_writes();
      pulse_start();
      send(8'h01, 2); send(8'h00, 0);
      send(8'h13, 3);
      pulse_start();
      chk("p5_busy_after_start", 32'(busy), 32'd1);
      send(8'h05, 1); send(8'h00, 4); send(8'h00, 2);
      repeat (3) tick();
      chk("p5_done", 32'(done), 32'd1);
      chk("p5_nwrites", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() == 1) begin
         chk("p5_a0", wq_addr[0], 32'h0000_0000);
         chk("p5_d0", wq_data[0], 32'h0000_0513);
      end

      // 6. Reset after two data bytes discards the partial word
      clear_writes();
      pulse_start();
      send(8'h01, 0); send(8'h00, 0);
      send(8'h13, 0); send(8'h05, 0);
      #3 rst = 1'b1;
      #1;
      chk("p6_rst_busy", 32'(busy), 32'd0);
      chk("p6_rst_addr", mem_addr,  32'h0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("p6_nwrites_mid", 32'(wq_addr.size()), 32'd0);
      pulse_start();
      send(8'h01, 0); send(8'h00, 0);
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
      repeat (3) tick();
      chk("p6_done", 32'(done), 32'd1);
      chk("p6_nwrites", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() == 1) begin
         chk("p6_a0", wq_addr[0], 32'h0000_0000);
         chk("p6_d0", wq_data[0], 32'hDDCC_BBAA);
      end

      // 7. Exactly MEM_WORDS (1024) words is legal and does not wrap
      clear_writes();
      pulse_start();
      send(8'h00, 0); send(8'h04, 0);
      chk("p7_no_err", 32'(err), 32'd0);
      for (int i = 0; i < 1024; i++) begin
         logic [15:0] iv;
         iv = 16'(i);
         send(iv[7:0], 0); send(iv[15:8], 0); send(8'h00, 0); send(8'hA5, 0);
      end
      repeat (3) tick();
      chk("p7_done", 32'(done), 32'd1);
      chk("p7_nwrites", 32'(wq_addr.size()), 32'd1024);
      if (wq_addr.size() == 1024) begin
         chk("p7_a_mid", wq_addr[300],  32'h0000_04B0);
         chk("p7_d_mid", wq_data[300],  32'hA500_012C);
         chk("p7_a_last", wq_addr[1023], 32'h0000_0FFC);
         chk("p7_d_last", wq_data[1023], 32'hA500_03FF);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Program loader that writes instruction words into the CPU's instruction memory over its write port. It receives a byte stream through a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive word addresses. The block holds the CPU in reset until a complete program has loaded, so the fetch side only ever reads a fully written image.

Parameters:
ADDRESS_WIDTH, 32, width of mem_addr (byte address)
DATA_WIDTH, 32, width of mem_wdata; fixed at 32 (4 bytes per word)
BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned
MEM_WORDS, 1024, instruction memory capacity in words; maximum legal program length

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a load; sampled only in IDLE, DONE or ERROR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid and byte_ready are both high at a rising edge
mem_we  output  1  instruction memory write enable, one-cycle pulse
mem_addr  output  ADDRESS_WIDTH  write byte address
mem_wdata  output  DATA_WIDTH  write data
cpu_rst  output  1  reset to CPU, high except in DONE
busy  output  1  load in progress (states LEN_LO through WRITE)
done  output  1  program loaded successfully
err  output  1  length header exceeded MEM_WORDS

Behaviour:
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- Reset (asynchronous, takes effect immediately, including mid-load):
  - state goes to IDLE;
  - byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0;
  - word and byte counters clear.
- Stream format:
  - 2-byte header giving the word count N, low byte first;
  - then 4*N data bytes, least significant byte of each word first.
- IDLE:
  - byte_ready=0, cpu_rst=1.
  - start -> LEN_LO; clear done, err and counters.
- LEN_LO:
  - byte_ready=1.
  - On transfer, latch N[7:0] and go to LEN_HI.
- LEN_HI:
  - byte_ready=1.
  - On transfer, form N = {byte_in, lo}.
  - N==0 -> DONE.
  - N>MEM_WORDS -> ERROR.
  - Otherwise -> DATA.
- DATA:
  - byte_ready=1.
  - A 2-bit byte index places each accepted byte at bits [8*idx+7:8*idx] of the word register.
  - On the transfer where idx==3 -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1;
  - mem_addr = BASE_ADDR + 4*word_idx;
  - mem_wdata = assembled word.
  - Next edge: word_idx increments. If the new word_idx==N -> DONE, else -> DATA.
- Throughput: the 4th byte is accepted at edge k, mem_we is high during cycle k..k+1, and the next byte can be accepted at edge k+2 at the earliest. Full-rate streaming takes 5 cycles per word.
- DONE:
  - done=1, cpu_rst=0, busy=0, byte_ready=0.
  - start -> LEN_LO; cpu_rst reasserts on that same edge.
- ERROR:
  - err=1, cpu_rst=1, byte_ready=0, and no writes are issued.
  - start -> LEN_LO with err cleared.
- start while busy is ignored.
- Gaps in byte_valid stall the machine in its current state with no side effects. mem_we stays 0 outside WRITE.
- Word index width is clog2(MEM_WORDS)+1 so that N==MEM_WORDS is legal and does not wrap. mem_addr arithmetic is modulo 2^ADDRESS_WIDTH.
- Bytes presented while byte_ready=0 are not consumed. The source must hold them.

Test Plan:
1. Reset, then idle for 10 cycles -> byte_ready=0, mem_we=0, cpu_rst=1, done=0, err=0. Assert rst asynchronously between edges -> outputs take reset values immediately.
2. start, stream 02 00 13 05 00 00 93 05 15 00 at full rate:
   - expect writes (0x0, 0x00000513) then (0x4, 0x00150593), one mem_we pulse each;
   - then done=1 and cpu_rst=0;
   - no other mem_we pulses.
3. start, header 00 00 -> DONE directly after the header, zero mem_we pulses, cpu_rst=0.
4. start, header 01 04 (N=1025) -> err=1, cpu_rst=1, byte_ready=0, no writes. Then start with a valid 1-word stream -> err clears and the word is written at 0x0.
5. Load 1 word with byte_valid randomly deasserted and start pulsed mid-load -> the word is still 0x00000513 at 0x0, the load is not restarted, and exactly one write occurs.
6. Assert rst after 2 data bytes of word 1, then restart with a 1-word program -> the partial word is never written, and the new word is written at BASE_ADDR.
